// File: rtl/commit_unit_if.sv
// commit_unit_if: groups the dispatch, CDB, order-queue, register-file and
// free-tag signals of the commit stage. The DUT uses the slave modport; the
// environment that drives it uses the master modport.
interface commit_unit_if #(
  parameter int TAG_WIDTH  = 5,
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  dispatch_valid;
  logic [TAG_WIDTH-1:0]  dispatch_tag;
  logic [REG_WIDTH-1:0]  dispatch_rd;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic [TAG_WIDTH-1:0]  oq_head_tag;
  logic                  oq_empty;
  logic                  commit_hold;
  logic                  oq_pop;
  logic                  rf_we;
  logic [REG_WIDTH-1:0]  rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  tag_free_valid;
  logic [TAG_WIDTH-1:0]  tag_free_tag;
  logic [15:0]           retire_count;

  modport master (
    output dispatch_valid, dispatch_tag, dispatch_rd,
    output cdb_valid, cdb_tag, cdb_data,
    output oq_head_tag, oq_empty, commit_hold,
    input  oq_pop, rf_we, rf_waddr, rf_wdata,
    input  tag_free_valid, tag_free_tag, retire_count
  );

  modport slave (
    input  dispatch_valid, dispatch_tag, dispatch_rd,
    input  cdb_valid, cdb_tag, cdb_data,
    input  oq_head_tag, oq_empty, commit_hold,
    output oq_pop, rf_we, rf_waddr, rf_wdata,
    output tag_free_valid, tag_free_tag, retire_count
  );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order commit stage behind the order queue. A completion
// table indexed by Rd tag tracks destination register, result data and a done
// bit; the order-queue head is committed (RF write + tag free) once done.
// Optional feature macro: COMMIT_BYPASS_EN lets a CDB broadcast for the head
// tag commit in the same cycle instead of waiting for its done bit.
module commit_unit #(
  parameter int TAG_WIDTH  = 5,
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic          clock,
  input logic          reset_n,
  commit_unit_if.slave bus
);
  localparam int ENTRIES = 1 << TAG_WIDTH;

  logic [ENTRIES-1:0]    done;
  logic [REG_WIDTH-1:0]  rd_mem   [ENTRIES];
  logic [DATA_WIDTH-1:0] data_mem [ENTRIES];
  logic                  head_done;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  commit_go;

`ifdef COMMIT_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = bus.cdb_valid && (bus.cdb_tag == bus.oq_head_tag);
  assign head_done  = done[bus.oq_head_tag] || bypass_hit;
  assign head_data  = bypass_hit ? bus.cdb_data : data_mem[bus.oq_head_tag];
`else
  assign head_done  = done[bus.oq_head_tag];
  assign head_data  = data_mem[bus.oq_head_tag];
`endif

  // Pop is held low during reset so the queue never sees a pop it will also reset.
  assign commit_go  = reset_n && !bus.oq_empty && !bus.commit_hold && head_done;
  assign bus.oq_pop = commit_go;

  // Done bits: CDB sets, commit clears, dispatch clears last so it always wins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      done <= '0;
    end else begin
      if (bus.cdb_valid)      done[bus.cdb_tag]      <= 1'b1;
      if (commit_go)          done[bus.oq_head_tag]  <= 1'b0;
      if (bus.dispatch_valid) done[bus.dispatch_tag] <= 1'b0;
    end
  end

  // Entry payload; reset leaves rd/data untouched since done gates their use.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (bus.dispatch_valid) rd_mem[bus.dispatch_tag] <= bus.dispatch_rd;
      if (bus.cdb_valid)      data_mem[bus.cdb_tag]    <= bus.cdb_data;
    end
  end

  // Registered commit outputs; address/data/tag hold between commits.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.rf_we          <= 1'b0;
      bus.rf_waddr       <= '0;
      bus.rf_wdata       <= '0;
      bus.tag_free_valid <= 1'b0;
      bus.tag_free_tag   <= '0;
      bus.retire_count   <= '0;
    end else begin
      bus.rf_we          <= commit_go;
      bus.tag_free_valid <= commit_go;
      if (commit_go) begin
        bus.rf_waddr     <= rd_mem[bus.oq_head_tag];
        bus.rf_wdata     <= head_data;
        bus.tag_free_tag <= bus.oq_head_tag;
        bus.retire_count <= bus.retire_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed stimulus with a scoreboard. Entries entering the
// modelled order queue push their expected RF write; a negedge monitor pops
// and checks every commit it observes.
module tb_commit_unit;
`ifdef COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  logic clock;
  logic reset_n;
  commit_unit_if bus ();

  commit_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_pop_cyc = -10;
  logic        pop_seen = 1'b0;
  logic [15:0] exp_retire = 16'd0;
  exp_t        sb[$];
  logic [4:0]  oq[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index used for latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: record pops and check every commit against the scoreboard.
  always @(negedge clock) begin
    if (bus.rf_we || bus.tag_free_valid) begin
      chk("rf_we", {31'd0, bus.rf_we}, 32'd1);
      chk("tag_free_valid", {31'd0, bus.tag_free_valid}, 32'd1);
      chk("commit_latency", cyc - last_pop_cyc, 32'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit: got waddr %0d wdata %0h, expected none", bus.rf_waddr, bus.rf_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, e.rd});
        chk("rf_wdata", bus.rf_wdata, e.data);
        chk("tag_free_tag", {27'd0, bus.tag_free_tag}, {27'd0, e.tag});
      end
      exp_retire = exp_retire + 16'd1;
      chk("retire_count", {16'd0, bus.retire_count}, {16'd0, exp_retire});
    end
    pop_seen = bus.oq_pop;
    if (bus.oq_pop) last_pop_cyc = cyc;
  end

  task automatic update_oq();
    if (oq.size() > 0) begin
      bus.oq_empty    = 1'b0;
      bus.oq_head_tag = oq[0];
    end else begin
      bus.oq_empty = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (pop_seen) begin
      chk("pop_nonempty", {31'd0, oq.size() > 0}, 32'd1);
      if (oq.size() > 0) void'(oq.pop_front());
    end
    update_oq();
    bus.dispatch_valid = 1'b0;
    bus.cdb_valid      = 1'b0;
  endtask

  task automatic check_pop(input string name, input logic exp);
    @(negedge clock);
    chk(name, {31'd0, bus.oq_pop}, {31'd0, exp});
  endtask

  task automatic enqueue(input logic [4:0] tag, input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    e.tag = tag;
    oq.push_back(tag);
    sb.push_back(e);
    update_oq();
  endtask

  task automatic dispatch(input logic [4:0] tag, input logic [4:0] rd);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_tag   = tag;
    bus.dispatch_rd    = rd;
    tick();
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    oq.delete();
    sb.delete();
    exp_retire = 16'd0;
    reset_n = 1'b1;
    update_oq();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk(name, sb.size(), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_tag   = '0;
    bus.dispatch_rd    = '0;
    bus.commit_hold    = 1'b0;

    // Reset with a live CDB hit on a non-empty head: still no pop.
    for (int i = 0; i < 2; i++) begin
      bus.cdb_valid   = 1'b1;
      bus.cdb_tag     = 5'd0;
      bus.cdb_data    = 32'h1234_5678;
      bus.oq_empty    = 1'b0;
      bus.oq_head_tag = 5'd0;
      check_pop("reset_no_pop", 1'b0);
      if (i == 1) begin
        chk("reset_rf_we", {31'd0, bus.rf_we}, 32'd0);
        chk("reset_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
        chk("reset_rf_wdata", bus.rf_wdata, 32'd0);
        chk("reset_free_valid", {31'd0, bus.tag_free_valid}, 32'd0);
        chk("reset_free_tag", {27'd0, bus.tag_free_tag}, 32'd0);
        chk("reset_retire", {16'd0, bus.retire_count}, 32'd0);
      end
      tick();
    end
    reset_n = 1'b1;
    update_oq();

    // Basic commit of tag 3 -> r7.
    dispatch(5'd3, 5'd7);
    enqueue(5'd3, 5'd7, 32'hDEAD_BEEF);
    cdb(5'd3, 32'hDEAD_BEEF);
    check_pop("basic_pop_cdb_cycle", BYP);
    tick();
    check_pop("basic_pop_next", !BYP);
    tick();
    drain("basic_drain");

    // Out-of-order completion, in-order commit.
    dispatch(5'd1, 5'd11);
    enqueue(5'd1, 5'd11, 32'h1111_1111);
    dispatch(5'd2, 5'd12);
    enqueue(5'd2, 5'd12, 32'h2222_2222);
    dispatch(5'd3, 5'd13);
    enqueue(5'd3, 5'd13, 32'h3333_3333);
    cdb(5'd3, 32'h3333_3333);
    check_pop("ooo_no_pop_3", 1'b0);
    tick();
    cdb(5'd2, 32'h2222_2222);
    check_pop("ooo_no_pop_2", 1'b0);
    tick();
    cdb(5'd1, 32'h1111_1111);
    check_pop("ooo_pop_cdb1", BYP);
    tick();
    if (!BYP) begin
      check_pop("ooo_pop_1", 1'b1);
      tick();
    end
    check_pop("ooo_pop_2", 1'b1);
    tick();
    check_pop("ooo_pop_3", 1'b1);
    tick();
    check_pop("ooo_idle", 1'b0);
    drain("ooo_drain");

    // Hold for 4 cycles with the head completing.
    dispatch(5'd5, 5'd21);
    enqueue(5'd5, 5'd21, 32'hCAFE_0005);
    bus.commit_hold = 1'b1;
    cdb(5'd5, 32'hCAFE_0005);
    for (int i = 0; i < 4; i++) begin
      check_pop("hold_no_pop", 1'b0);
      chk("hold_no_we", {31'd0, bus.rf_we}, 32'd0);
      tick();
    end
    bus.commit_hold = 1'b0;
    check_pop("hold_release_pop", 1'b1);
    tick();
    drain("hold_drain");

    // Empty queue with a stale head tag that is done.
    dispatch(5'd6, 5'd22);
    cdb(5'd6, 32'h0BAD_0006);
    tick();
    bus.oq_head_tag = 5'd6;
    check_pop("empty_no_pop_a", 1'b0);
    tick();
    bus.oq_head_tag = 5'd6;
    check_pop("empty_no_pop_b", 1'b0);
    tick();
    enqueue(5'd6, 5'd22, 32'h0BAD_0006);
    check_pop("empty_filled_pop", 1'b1);
    tick();
    drain("empty_drain");

    // Reset mid-stream while tag 4 is done at the head.
    dispatch(5'd4, 5'd9);
    oq.push_back(5'd4);
    update_oq();
    bus.commit_hold = 1'b1;
    cdb(5'd4, 32'h4444_4444);
    tick();
    bus.commit_hold = 1'b0;
    reset_n = 1'b0;
    check_pop("midreset_no_pop", 1'b0);
    tick();
    oq.delete();
    sb.delete();
    exp_retire = 16'd0;
    reset_n = 1'b1;
    enqueue(5'd4, 5'd9, 32'h5555_5555);
    check_pop("midreset_stale_a", 1'b0);
    tick();
    check_pop("midreset_stale_b", 1'b0);
    tick();
    cdb(5'd4, 32'h5555_5555);
    check_pop("midreset_fresh_cdb", BYP);
    tick();
    if (!BYP) begin
      check_pop("midreset_fresh_pop", 1'b1);
      tick();
    end
    drain("midreset_drain");

    // Counter wrap: 65,536 back-to-back commits alternating tags 8 and 9.
    do_reset();
    dispatch(5'd8, 5'd1);
    dispatch(5'd9, 5'd2);
    for (int i = 0; i < 65536; i++) begin
      logic [4:0] t;
      t = (i % 2 == 1) ? 5'd9 : 5'd8;
      enqueue(t, (t == 5'd8) ? 5'd1 : 5'd2, i);
      cdb(t, i);
      tick();
    end
    drain("wrap_drain");
    chk("retire_wrap", {16'd0, bus.retire_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/commit_unit.md
# commit_unit

In-order commit stage that sits directly downstream of the order queue. It holds a 32-entry completion table indexed by Rd tag. Entries are filled by dispatch (destination register) and by the CDB (result data). When the tag at the order-queue head is complete, the unit pops the queue, writes the architectural register file and returns the tag to the free-tag pool, at one instruction per cycle.

## Interface
- TAG_WIDTH, 5, Rd tag width; the table has 2^TAG_WIDTH entries.
- REG_WIDTH, 5, architectural register address width.
- DATA_WIDTH, 32, result data width.

- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dispatch_valid  in  1  a new instruction was dispatched this cycle.
- dispatch_tag  in  TAG_WIDTH  Rd tag allocated to that instruction.
- dispatch_rd  in  REG_WIDTH  architectural destination register.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_WIDTH  tag being completed.
- cdb_data  in  DATA_WIDTH  result value.
- oq_head_tag  in  TAG_WIDTH  order-queue head (its outData).
- oq_empty  in  1  order queue empty.
- commit_hold  in  1  stall commit (register-file port busy).
- oq_pop  out  1  pop the order-queue head (drives its out_data); combinational.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_WIDTH  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- tag_free_valid  out  1  tag returned to the free pool.
- tag_free_tag  out  TAG_WIDTH  returned tag.
- retire_count  out  16  instructions committed since reset.

## Operation
- Per-entry state: done bit, rd (REG_WIDTH), data (DATA_WIDTH).
- Dispatch: at the edge, entry[dispatch_tag].rd <= dispatch_rd and done <= 0.
- CDB: at the edge, entry[cdb_tag].data <= cdb_data and done <= 1.
- Same tag on dispatch and CDB in one cycle is illegal. RTL gives dispatch priority, so done ends at 0.
- Commit condition: `commit_go = !oq_empty && !commit_hold && done[oq_head_tag]`.
- oq_pop = commit_go.
- At the edge where commit_go is 1:
  - done[head] <= 0;
  - rf_we <= 1, with rf_waddr/rf_wdata taken from the head entry;
  - tag_free_valid <= 1, tag_free_tag <= head;
  - retire_count increments.
- Otherwise rf_we and tag_free_valid return to 0. Address, data and tag outputs hold their last values.
- Commit order is strictly the order-queue order. No entry other than the head is ever committed.
- retire_count is 16-bit and wraps from 0xFFFF to 0x0000.
- Dispatch of the tag being freed in the same cycle: dispatch wins, done=0. This cannot happen legally because the tag reaches the pool one cycle later.

## Timing
- Reset (reset_n=0 at an edge): all done bits are cleared; rd/data are unchanged.
  - rf_we=0, rf_waddr=0, rf_wdata=0, tag_free_valid=0, tag_free_tag=0, retire_count=0.
  - oq_pop is forced to 0 while reset_n=0.
- Reset mid-operation discards all pending completions. The order queue is reset by the same signal.
- Commit latency: oq_pop in cycle N; rf_we and tag_free_valid high in cycle N+1.
- CDB completion of the head in cycle N: done is visible in N+1, so oq_pop is in N+1 (without the bypass below).
- Throughput is one commit per cycle with back-to-back pops. The order queue presents the new head in the cycle after a pop.
- oq_empty=1 blocks commit regardless of done bits and of a stale oq_head_tag.
- commit_hold=1 blocks oq_pop with no state change to the head entry. Commit resumes in the first cycle with hold=0.

## Configuration
- COMMIT_BYPASS_EN defined:
  - If cdb_valid && cdb_tag==oq_head_tag && !oq_empty && !commit_hold in cycle N, oq_pop=1 in N.
  - rf_wdata in N+1 equals that cdb_data.
  - done for that tag ends at 0 (the commit clear beats the CDB set).
- COMMIT_BYPASS_EN undefined: the CDB-to-pop path is removed, and the minimum CDB-to-pop latency is 1 cycle.

## Test plan
- Reset: drive reset_n=0 for 2 cycles with cdb_valid=1. Required: all outputs 0, retire_count=0, no oq_pop.
- Basic commit:
  - Stimulus: dispatch tag 3, rd 7; CDB tag 3, data 0xDEADBEEF in cycle 5; head=3, not empty.
  - Without bypass: oq_pop in cycle 6; rf_we=1, waddr=7, wdata=0xDEADBEEF and tag_free_tag=3 in cycle 7.
  - With bypass: oq_pop in cycle 5, outputs in cycle 6.
- Out-of-order completion:
  - Stimulus: dispatch tags 1, 2, 3 in order; CDB completes 3, then 2, then 1.
  - Required: no pop until tag 1 is done, then three consecutive pops; rf writes in order 1, 2, 3.
- Hold and empty:
  - Stimulus: head done with commit_hold=1 for 4 cycles.
  - Required: no pop and no rf_we; pop in the first cycle after hold drops.
  - With oq_empty=1 and done[head]=1: no pop.
- Counter wrap: preload via 65,536 commits. Required: retire_count reads 0x0000 after the last commit.
- Reset mid-stream: assert reset_n=0 while tag 4 is done and at the head. Required: after reset, no commit of tag 4 until a fresh CDB for it.
